// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches a load/store, waits LATENCY cycles, then accesses a word RAM.
// Exactly one done or error pulse per request; a held request is serviced once (RELEASE waits for it to drop).
module data_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    input  logic [2:0]  mem_size,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stat_mem_read_done,
    output logic        stat_mem_write_done,
    output logic        stat_mem_error,
    output logic        busy
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LAT, RESPOND, RELEASE} state_t;

    state_t      state;
    logic [3:0]  lat_cnt;
    logic        op_rd;
    logic        op_wr;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] mem [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          size_ok;
    logic          align_ok;
    logic          range_ok;
    logic          legal;
    logic          commit;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_val;

    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign range_ok = (req_addr >= BASE_ADDR) && (offset < SPAN);
    assign legal    = !(op_rd && op_wr) && size_ok && align_ok && range_ok;
    // The commit edge is the one that moves WAIT_LAT into RESPOND.
    assign commit   = (state == WAIT_LAT) && (lat_cnt == 4'd0);

    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        byte_en  = 4'b0000;
        wr_lanes = req_wdata;
        case (req_size)
            3'b000: begin
                size_ok  = 1'b1;
                align_ok = 1'b1;
                byte_en  = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                size_ok  = 1'b1;
                align_ok = !req_addr[0];
                byte_en  = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                size_ok  = 1'b1;
                align_ok = (req_addr[1:0] == 2'b00);
                byte_en  = 4'b1111;
            end
            // Unsigned sizes only make sense for loads.
            3'b100: begin
                size_ok  = op_rd;
                align_ok = 1'b1;
            end
            3'b101: begin
                size_ok  = op_rd;
                align_ok = !req_addr[0];
            end
            default: ;
        endcase
    end

    assign rd_word = mem[word_idx];
    assign ld_byte = rd_word[8*req_addr[1:0] +: 8];
    assign ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (req_size)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = rd_word;
        endcase
    end

    // RAM has no reset; an abandoned request never reaches commit because state resets.
    always_ff @(posedge clk) begin
        if (commit && legal && op_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            lat_cnt             <= 4'd0;
            op_rd               <= 1'b0;
            op_wr               <= 1'b0;
            req_size            <= 3'b000;
            req_addr            <= 32'd0;
            req_wdata           <= 32'd0;
            read_data           <= 32'd0;
            stat_mem_read_done  <= 1'b0;
            stat_mem_write_done <= 1'b0;
            stat_mem_error      <= 1'b0;
            busy                <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_mem_read || ctrl_mem_write) begin
                        op_rd     <= ctrl_mem_read;
                        op_wr     <= ctrl_mem_write;
                        req_size  <= mem_size;
                        req_addr  <= address;
                        req_wdata <= write_data;
                        lat_cnt   <= LAT_INIT;
                        busy      <= 1'b1;
                        state     <= WAIT_LAT;
                    end
                end
                WAIT_LAT: begin
                    if (lat_cnt == 4'd0) begin
                        state <= RESPOND;
                        if (!legal) begin
                            stat_mem_error <= 1'b1;
                        end else if (op_wr) begin
                            stat_mem_write_done <= 1'b1;
                        end else begin
                            read_data          <= load_val;
                            stat_mem_read_done <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    stat_mem_read_done  <= 1'b0;
                    stat_mem_write_done <= 1'b0;
                    stat_mem_error      <= 1'b0;
                    state               <= RELEASE;
                end
                default: begin
                    if (!ctrl_mem_read && !ctrl_mem_write) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
